// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: standard rate table plus custom divisor, producing
// a 1x transmit bit tick and an OVERSAMPLE-x receive tick with phase count.
module baud_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 19
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [3:0]                    baud_sel,
  input  logic [CNT_W-1:0]              custom_div,
  output logic                          tx_tick,
  output logic                          rx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
  output logic                          baud_valid,
  output logic [CNT_W-1:0]              tx_div
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  function automatic logic [63:0] rate_of(input logic [3:0] code);
    case (code)
      4'd0:    return 64'd300;
      4'd1:    return 64'd1200;
      4'd2:    return 64'd2400;
      4'd3:    return 64'd4800;
      4'd4:    return 64'd9600;
      4'd5:    return 64'd19200;
      4'd6:    return 64'd38400;
      4'd7:    return 64'd57600;
      4'd8:    return 64'd115200;
      4'd9:    return 64'd230400;
      4'd10:   return 64'd460800;
      4'd11:   return 64'd921600;
      default: return 64'd0;
    endcase
  endfunction

  // Rounded divide; codes without a rate yield 0 instead of dividing by zero.
  function automatic logic [63:0] div_round(input logic [63:0] rate, input logic [63:0] mult);
    logic [63:0] den;
    den = rate * mult;
    if (den == 64'd0) return 64'd0;
    return (64'(CLK_FREQ) + den / 64'd2) / den;
  endfunction

  logic [CNT_W-1:0] tx_tab [16];
  logic [CNT_W-1:0] rx_tab [16];

  for (genvar g = 0; g < 16; g++) begin : g_tab
    assign tx_tab[g] = CNT_W'(div_round(rate_of(4'(g)), 64'd1));
    assign rx_tab[g] = CNT_W'(div_round(rate_of(4'(g)), 64'(OVERSAMPLE)));
  end

  logic [CNT_W-1:0] lk_tx, lk_rx;
  logic             lk_valid;

  always_comb begin
    lk_tx    = '0;
    lk_rx    = '0;
    lk_valid = 1'b0;
    if (baud_sel < 4'd12) begin
      lk_tx    = tx_tab[baud_sel];
      lk_rx    = rx_tab[baud_sel];
      lk_valid = 1'b1;
    end else if (baud_sel == 4'hF && custom_div >= CNT_W'(2 * OVERSAMPLE)) begin
      lk_tx    = custom_div;
      lk_rx    = custom_div >> PH_W;
      lk_valid = 1'b1;
    end
  end

  logic [3:0]       sel_q;
  logic [CNT_W-1:0] cdiv_q;
  logic             load_pending;
  logic [CNT_W-1:0] rx_div;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             load;

  assign load = load_pending || (baud_sel != sel_q) ||
                (baud_sel == 4'hF && custom_div != cdiv_q);

  // A load always wins over running so a pending terminal-count tick is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= '0;
      cdiv_q       <= '0;
      load_pending <= 1'b1;
      tx_div       <= '0;
      rx_div       <= '0;
      baud_valid   <= 1'b0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      rx_phase     <= '0;
      tx_tick      <= 1'b0;
      rx_tick      <= 1'b0;
    end else if (load) begin
      sel_q        <= baud_sel;
      cdiv_q       <= custom_div;
      load_pending <= 1'b0;
      tx_div       <= lk_tx;
      rx_div       <= lk_rx;
      baud_valid   <= lk_valid;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      rx_phase     <= '0;
      tx_tick      <= 1'b0;
      rx_tick      <= 1'b0;
    end else if (enable && baud_valid) begin
      if (tx_cnt == tx_div - CNT_W'(1)) begin
        tx_cnt  <= '0;
        tx_tick <= 1'b1;
      end else begin
        tx_cnt  <= tx_cnt + CNT_W'(1);
        tx_tick <= 1'b0;
      end
      if (rx_cnt == rx_div - CNT_W'(1)) begin
        rx_cnt   <= '0;
        rx_tick  <= 1'b1;
        rx_phase <= rx_phase + PH_W'(1);
      end else begin
        rx_cnt  <= rx_cnt + CNT_W'(1);
        rx_tick <= 1'b0;
      end
    end else begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      rx_phase <= '0;
      tx_tick  <= 1'b0;
      rx_tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 100 MHz / 16x oversampling; expected
// divisors and tick spacings are hand-computed constants.
module tb_baud_tick_gen;

  localparam int CNT_W = 19;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [3:0]       baud_sel;
  logic [CNT_W-1:0] custom_div;
  logic             tx_tick;
  logic             rx_tick;
  logic [3:0]       rx_phase;
  logic             baud_valid;
  logic [CNT_W-1:0] tx_div;

  int n_checks = 0;
  int n_pass   = 0;

  int tx_exp [12] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109};
  int rx_exp [12] = '{20833, 5208, 2604, 1302, 651, 326, 163, 109, 54, 27, 14, 7};

  baud_tick_gen #(
    .CLK_FREQ  (100_000_000),
    .OVERSAMPLE(16),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .baud_sel  (baud_sel),
    .custom_div(custom_div),
    .tx_tick   (tx_tick),
    .rx_tick   (rx_tick),
    .rx_phase  (rx_phase),
    .baud_valid(baud_valid),
    .tx_div    (tx_div)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until the chosen tick is seen; -1 when the budget runs out.
  task automatic wait_tick(input bit use_rx, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      seen = use_rx ? rx_tick : tx_tick;
    end
    if (!seen) n = -1;
  endtask

  task automatic count_ticks(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      cnt += int'(tx_tick) + int'(rx_tick);
    end
  endtask

  initial begin
    int n;
    int cnt;

    reset      = 1'b1;
    enable     = 1'b0;
    baud_sel   = 4'd8;
    custom_div = '0;
    step(3);
    check("rst_tx_tick", tx_tick, 0);
    check("rst_rx_tick", rx_tick, 0);
    check("rst_rx_phase", rx_phase, 0);
    check("rst_baud_valid", baud_valid, 0);
    check("rst_tx_div", tx_div, 0);

    // First edge after reset always loads
    reset  = 1'b0;
    enable = 1'b1;
    step(1);
    check("load_valid", baud_valid, 1);
    check("load_tx_div", tx_div, 868);
    check("load_tx_tick", tx_tick, 0);
    wait_tick(0, 2000, n);
    check("first_tx", n, 868);
    wait_tick(0, 2000, n);
    check("tx_period", n, 868);
    step(1);
    check("tx_width", tx_tick, 0);
    wait_tick(0, 2000, n);
    check("tx_after_width", n, 867);

    // Enable low mid-period
    step(300);
    enable = 1'b0;
    count_ticks(50, cnt);
    check("en_low_ticks", cnt, 0);
    check("en_low_phase", rx_phase, 0);
    check("en_low_tx_div", tx_div, 868);
    enable = 1'b1;
    wait_tick(0, 2000, n);
    check("en_rise_tx", n, 868);

    // rx period and phase wrap from a fresh enable rise
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      wait_tick(1, 200, n);
      check("rx_period", n, 54);
      check("rx_phase", rx_phase, j % 16);
    end

    // Switch 4 -> 8 with tx_cnt at 5000
    baud_sel = 4'd4;
    step(1);
    check("sel4_tx_div", tx_div, 10417);
    step(5000);
    baud_sel = 4'd8;
    step(1);
    check("switch_tx_tick", tx_tick, 0);
    check("switch_rx_phase", rx_phase, 0);
    check("switch_tx_div", tx_div, 868);
    wait_tick(0, 2000, n);
    check("switch_next_tx", n, 868);

    // Change on the terminal-count edge drops the tick
    step(867);
    baud_sel = 4'd4;
    step(1);
    check("tc_drop_tick", tx_tick, 0);
    check("tc_drop_tx_div", tx_div, 10417);

    // Full rate table
    for (int c = 0; c < 12; c++) begin
      baud_sel = 4'(c);
      step(1);
      check("table_tx_div", tx_div, tx_exp[c]);
      check("table_valid", baud_valid, 1);
      if (c >= 8) begin
        wait_tick(1, 2000, n);
        check("table_first_rx", n, rx_exp[c]);
        wait_tick(0, 2000, n);
        check("table_first_tx", n, tx_exp[c] - rx_exp[c]);
        wait_tick(0, 2000, n);
        check("table_tx_period", n, tx_exp[c]);
      end
    end

    // Custom divisor mode
    baud_sel   = 4'hF;
    custom_div = 19'd1000;
    step(1);
    check("cust_valid", baud_valid, 1);
    check("cust_tx_div", tx_div, 1000);
    wait_tick(1, 2000, n);
    check("cust_first_rx", n, 62);
    wait_tick(0, 2000, n);
    check("cust_first_tx", n, 938);
    wait_tick(0, 2000, n);
    check("cust_tx_period", n, 1000);

    custom_div = 19'd31;
    step(1);
    check("cust31_valid", baud_valid, 0);
    check("cust31_tx_div", tx_div, 0);
    count_ticks(500, cnt);
    check("cust31_ticks", cnt, 0);

    custom_div = 19'd32;
    step(1);
    check("cust32_valid", baud_valid, 1);
    check("cust32_tx_div", tx_div, 32);
    wait_tick(1, 200, n);
    check("cust32_first_rx", n, 2);
    wait_tick(1, 200, n);
    check("cust32_rx_period", n, 2);

    // Invalid codes
    for (int c = 12; c < 15; c++) begin
      baud_sel = 4'(c);
      step(1);
      check("inv_valid", baud_valid, 0);
      check("inv_tx_div", tx_div, 0);
    end
    baud_sel = 4'hC;
    count_ticks(3000, cnt);
    check("inv_ticks", cnt, 0);

    // Reset mid-run together with a selection change
    baud_sel = 4'd11;
    step(200);
    check("pre_rst_tx_div", tx_div, 109);
    reset    = 1'b1;
    baud_sel = 4'd8;
    step(1);
    check("mid_rst_tx_div", tx_div, 0);
    check("mid_rst_valid", baud_valid, 0);
    check("mid_rst_phase", rx_phase, 0);
    check("mid_rst_ticks", int'(tx_tick) + int'(rx_tick), 0);
    step(2);
    reset = 1'b0;
    step(1);
    check("post_rst_tx_div", tx_div, 868);
    check("post_rst_valid", baud_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART transmit and receive paths. It holds the standard rate table (300 to 921600 baud) computed at elaboration from the clock frequency, adds a runtime custom-divisor mode, and produces registered single-cycle ticks. There is a 1x bit tick for the transmitter and an OVERSAMPLE-x tick with a sub-bit phase count for the receiver. It sits between the baud-select control register and the TX/RX shift engines.

## Interface
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- OVERSAMPLE, 16: receive ticks per bit period. Must be a power of two, at least 2.
- CNT_W, 19: divisor and counter width. Must hold round(CLK_FREQ/300).
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high runs the counters; low clears the counters and holds both ticks low.
- baud_sel  in  4  rate code. 0..B = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600. C..E are invalid. F selects custom_div.
- custom_div  in  CNT_W  clocks per bit when baud_sel = F.
- tx_tick  out  1  one-cycle pulse per bit period.
- rx_tick  out  1  one-cycle pulse per 1/OVERSAMPLE bit period.
- rx_phase  out  log2(OVERSAMPLE)  count of rx_ticks since the last load, modulo OVERSAMPLE.
- baud_valid  out  1  the loaded selection is usable.
- tx_div  out  CNT_W  the active TX divisor.

## Operation
- **Table divisors.** Computed by a constant function as tx_div = (CLK_FREQ + rate/2) / rate and rx_div = (CLK_FREQ + rate*OVERSAMPLE/2) / (rate*OVERSAMPLE). Integer arithmetic is done at 64 bits, then truncated to CNT_W.
  - At 100 MHz: code 0 gives 333333/20833. Code 4 gives 10417/651. Code 8 gives 868/54. Code B gives 109/7.
- **Custom mode (code F).** tx_div = custom_div and rx_div = custom_div >> log2(OVERSAMPLE).
  - Valid only if custom_div >= 2*OVERSAMPLE.
- **Invalid selections.** Codes C..E, or F with a too-small custom_div, give baud_valid = 0, tx_div = 0, and both ticks held low.
- **Shadow registers.** sel_q, cdiv_q and a load_pending flag.
- **Load event.** A load occurs in any cycle where load_pending = 1, or baud_sel != sel_q, or (baud_sel == F and custom_div != cdiv_q). On a load edge:
  - capture sel_q and cdiv_q;
  - register tx_div, rx_div and baud_valid;
  - clear tx_cnt, rx_cnt and rx_phase;
  - drive both ticks to 0;
  - clear load_pending.
- **Run cycle.** Applies when there is no load, enable = 1 and baud_valid = 1.
  - tx_cnt: if tx_cnt == tx_div-1, tx_cnt <= 0 and tx_tick <= 1; otherwise tx_cnt + 1 and tx_tick <= 0.
  - rx_cnt: independently, the same rule against rx_div. On each rx_tick, rx_phase increments and wraps at OVERSAMPLE.
- **enable = 0 (no load).** Counters and rx_phase clear to 0 and ticks are 0. Shadow registers, tx_div and baud_valid are kept.
- The TX and RX counters are not phase-locked to each other. Both restart together on a load or an enable rise.

## Timing
- **Reset values.** tx_tick = 0, rx_tick = 0, rx_phase = 0, baud_valid = 0, tx_div = 0. Internally, counters = 0, sel_q = 0, cdiv_q = 0 and load_pending = 1.
- **First cycle after reset.** A load always occurs, so outputs reflect baud_sel one cycle after reset deasserts.
- **Selection change.** A change seen at edge k is loaded at edge k. The new baud_valid and tx_div are visible from edge k.
- **First ticks.** With enable high, the first tx_tick is registered at edge k + tx_div. The first rx_tick is at edge k + rx_div.
- **Steady state.** Tick period equals the divisor exactly, and each tick is high for exactly 1 cycle.
- **Enable rise.** With enable rising at edge e (high in the cycle before edge e+1), the first tx_tick is at edge e + tx_div.
- **Change while ticking.** A selection change in the same cycle as a terminal count gives a load with tick 0; the pending tick is dropped.
- **Simultaneous reset and change.** Reset has priority over everything.
- **No latency through lookup.** The divisor table is combinational from baud_sel into the load registers.

## Test plan
- Reset, then baud_sel = 8, enable = 1 → baud_valid = 1 and tx_div = 868. tx_tick is every 868 cycles. rx_tick is every 54 cycles. rx_phase steps 0..15 and wraps.
- baud_sel = B → tx_div = 109 and rx period 7. Check all 12 table codes against the rounded values at 100 MHz, e.g. code 0 = 333333.
- Switch baud_sel from 4 to 8 mid-period (tx_cnt = 5000) → no tick on the change edge. The next tx_tick is exactly 868 cycles later and rx_phase = 0.
- baud_sel = F with custom_div = 1000 → tx period 1000, rx period 62. Then custom_div = 31 → baud_valid = 0 and both ticks are low.
- baud_sel = C → baud_valid = 0, tx_div = 0, and no ticks for 1e6 cycles.
- Drop enable for 50 cycles mid-period, then raise it → ticks are low while enable is low. The first tx_tick follows tx_div cycles after the rise. Asserting reset mid-run clears all outputs on the next edge.
